// File: rtl/inst_mem_responder.sv
// Instruction memory endpoint: one fetch in flight, fixed read latency, val/rdy request and response.
// A host load port fills the backing array while the block is idle.
module inst_mem_responder #(
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int MEM_DATA_WIDTH = 16,
  parameter int MEM_DEPTH      = 256,
  parameter int READ_LATENCY   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      req_rdy,
  input  logic                      req_val,
  input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
  input  logic                      resp_rdy,
  output logic                      resp_val,
  output logic [MEM_DATA_WIDTH-1:0] resp_inst,
  input  logic                      load_val,
  input  logic [MEM_ADDR_WIDTH-1:0] load_addr,
  input  logic [MEM_DATA_WIDTH-1:0] load_data,
  output logic                      load_rdy,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_e;

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [MEM_ADDR_WIDTH:0] DEPTH_LIM = (MEM_ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(READ_LATENCY - 1);

  // Handshake rules: a transfer happens on a rising edge where val and rdy are both 1.
  // req_rdy/load_rdy depend only on the state register and load_val; resp_val is a flop.

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      resp_val_q, resp_val_d;
  logic [MEM_DATA_WIDTH-1:0] resp_inst_q, resp_inst_d;

  logic [MEM_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [MEM_ADDR_WIDTH-1:0] rd_addr;
  logic                      rd_in_range;
  logic [MEM_DATA_WIDTH-1:0] rd_data;
  logic                      ld_in_range;

  assign load_rdy  = (state_q == IDLE);
  assign req_rdy   = (state_q == IDLE) && !load_val;
  assign resp_val  = resp_val_q;
  assign resp_inst = resp_inst_q;
  assign state_dbg = state_q;

  // With a latency of 1 the read happens on the accepting edge, before addr_q holds the address.
  assign rd_addr     = (state_q == IDLE) ? req_addr : addr_q;
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_LIM);
  assign rd_data     = rd_in_range ? mem[rd_addr[IDX_W-1:0]] : '0;
  assign ld_in_range = ({1'b0, load_addr} < DEPTH_LIM);

  always_ff @(posedge clk) begin
    if (load_val && load_rdy && ld_in_range) begin
      mem[load_addr[IDX_W-1:0]] <= load_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    resp_val_d  = resp_val_q;
    resp_inst_d = resp_inst_q;
    case (state_q)
      IDLE: begin
        if (req_val && req_rdy) begin
          addr_d = req_addr;
          if (READ_LATENCY == 1) begin
            state_d     = RESPOND;
            resp_val_d  = 1'b1;
            resp_inst_d = rd_data;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d     = RESPOND;
          resp_val_d  = 1'b1;
          resp_inst_d = rd_data;
        end
      end
      RESPOND: begin
        if (resp_rdy) begin
          state_d     = IDLE;
          resp_val_d  = 1'b0;
          resp_inst_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      resp_val_q  <= 1'b0;
      resp_inst_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      resp_val_q  <= resp_val_d;
      resp_inst_q <= resp_inst_d;
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: three instances cover latency 2 (depth 256),
// latency 4 (depth 128) and latency 1 (depth 256).
module tb_inst_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_rdy   [3];
  logic        req_val   [3];
  logic [7:0]  req_addr  [3];
  logic        resp_rdy  [3];
  logic        resp_val  [3];
  logic [15:0] resp_inst [3];
  logic        load_val  [3];
  logic [7:0]  load_addr [3];
  logic [15:0] load_data [3];
  logic        load_rdy  [3];
  logic [1:0]  state_dbg [3];

  int checks = 0;
  int errors = 0;

  inst_mem_responder #(.MEM_DEPTH(256), .READ_LATENCY(2)) u_dut0 (
    .clk(clk), .reset(reset), .req_rdy(req_rdy[0]), .req_val(req_val[0]), .req_addr(req_addr[0]),
    .resp_rdy(resp_rdy[0]), .resp_val(resp_val[0]), .resp_inst(resp_inst[0]),
    .load_val(load_val[0]), .load_addr(load_addr[0]), .load_data(load_data[0]),
    .load_rdy(load_rdy[0]), .state_dbg(state_dbg[0]));

  inst_mem_responder #(.MEM_DEPTH(128), .READ_LATENCY(4)) u_dut1 (
    .clk(clk), .reset(reset), .req_rdy(req_rdy[1]), .req_val(req_val[1]), .req_addr(req_addr[1]),
    .resp_rdy(resp_rdy[1]), .resp_val(resp_val[1]), .resp_inst(resp_inst[1]),
    .load_val(load_val[1]), .load_addr(load_addr[1]), .load_data(load_data[1]),
    .load_rdy(load_rdy[1]), .state_dbg(state_dbg[1]));

  inst_mem_responder #(.MEM_DEPTH(256), .READ_LATENCY(1)) u_dut2 (
    .clk(clk), .reset(reset), .req_rdy(req_rdy[2]), .req_val(req_val[2]), .req_addr(req_addr[2]),
    .resp_rdy(resp_rdy[2]), .resp_val(resp_val[2]), .resp_inst(resp_inst[2]),
    .load_val(load_val[2]), .load_addr(load_addr[2]), .load_data(load_data[2]),
    .load_rdy(load_rdy[2]), .state_dbg(state_dbg[2]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rl_of(input int u);
    case (u)
      0: return 2;
      1: return 4;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic do_load(input int u, input logic [7:0] a, input logic [15:0] d);
    load_val[u]  = 1'b1;
    load_addr[u] = a;
    load_data[u] = d;
    #1;
    check($sformatf("u%0d load_rdy", u), 32'(load_rdy[u]), 32'd1);
    tick();
    load_val[u] = 1'b0;
  endtask

  task automatic do_read(input int u, input logic [7:0] a, input logic [15:0] exp_d, input int bp);
    int lat;
    resp_rdy[u] = (bp == 0);
    req_val[u]  = 1'b1;
    req_addr[u] = a;
    #1;
    check($sformatf("u%0d req_rdy idle", u), 32'(req_rdy[u]), 32'd1);
    tick();
    req_val[u]  = 1'b0;
    req_addr[u] = 8'hFF;
    check($sformatf("u%0d req_rdy busy", u), 32'(req_rdy[u]), 32'd0);
    check($sformatf("u%0d state after accept", u), 32'(state_dbg[u]),
          (rl_of(u) == 1) ? 32'd2 : 32'd1);
    lat = 1;
    while (!resp_val[u] && lat < 20) begin
      tick();
      lat++;
    end
    check($sformatf("u%0d latency", u), 32'(lat), 32'(rl_of(u)));
    check($sformatf("u%0d resp_inst", u), 32'(resp_inst[u]), 32'(exp_d));
    for (int i = 0; i < bp; i++) begin
      check($sformatf("u%0d bp resp_val %0d", u, i), 32'(resp_val[u]), 32'd1);
      check($sformatf("u%0d bp resp_inst %0d", u, i), 32'(resp_inst[u]), 32'(exp_d));
      tick();
    end
    resp_rdy[u] = 1'b1;
    tick();
    check($sformatf("u%0d resp_val done", u), 32'(resp_val[u]), 32'd0);
    check($sformatf("u%0d resp_inst done", u), 32'(resp_inst[u]), 32'd0);
    check($sformatf("u%0d req_rdy done", u), 32'(req_rdy[u]), 32'd1);
    check($sformatf("u%0d state done", u), 32'(state_dbg[u]), 32'd0);
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      req_val[u]   = 1'b1;
      req_addr[u]  = 8'h00;
      resp_rdy[u]  = 1'b1;
      load_val[u]  = 1'b0;
      load_addr[u] = 8'h00;
      load_data[u] = 16'h0000;
    end
    reset = 1'b0;

    // 1: reset with req_val held high
    tick();
    tick();
    for (int u = 0; u < 3; u++) begin
      check($sformatf("u%0d rst resp_val", u), 32'(resp_val[u]), 32'd0);
      check($sformatf("u%0d rst resp_inst", u), 32'(resp_inst[u]), 32'd0);
      check($sformatf("u%0d rst state", u), 32'(state_dbg[u]), 32'd0);
      check($sformatf("u%0d rst req_rdy", u), 32'(req_rdy[u]), 32'd1);
      check($sformatf("u%0d rst load_rdy", u), 32'(load_rdy[u]), 32'd1);
    end
    load_val[0] = 1'b1;
    #1;
    check("u0 rst req_rdy with load", 32'(req_rdy[0]), 32'd0);
    load_val[0] = 1'b0;
    for (int u = 0; u < 3; u++) req_val[u] = 1'b0;
    reset = 1'b1;
    tick();
    for (int u = 0; u < 3; u++)
      check($sformatf("u%0d no accept in reset", u), 32'(state_dbg[u]), 32'd0);

    // 2 and 3: basic read, then the same read under backpressure
    do_load(0, 8'h05, 16'hA3C1);
    do_read(0, 8'h05, 16'hA3C1, 0);
    do_read(0, 8'h05, 16'hA3C1, 4);

    // 4: load and request collide; the load wins and the request is taken next cycle
    load_val[0]  = 1'b1;
    load_addr[0] = 8'h05;
    load_data[0] = 16'h1234;
    req_val[0]   = 1'b1;
    req_addr[0]  = 8'h05;
    #1;
    check("u0 collide req_rdy", 32'(req_rdy[0]), 32'd0);
    check("u0 collide load_rdy", 32'(load_rdy[0]), 32'd1);
    tick();
    load_val[0] = 1'b0;
    req_val[0]  = 1'b0;
    check("u0 collide no accept", 32'(state_dbg[0]), 32'd0);
    do_read(0, 8'h05, 16'h1234, 0);

    // 5: out-of-range write dropped (no aliasing onto 0x48), out-of-range read is zero
    do_load(1, 8'h07, 16'h5A5A);
    do_load(1, 8'h48, 16'h1111);
    do_load(1, 8'hC8, 16'hBEEF);
    do_read(1, 8'hC8, 16'h0000, 0);
    do_read(1, 8'h48, 16'h1111, 0);
    do_read(1, 8'h07, 16'h5A5A, 0);

    // 6: reset one edge after accept abandons the request
    req_val[1]  = 1'b1;
    req_addr[1] = 8'h07;
    tick();
    req_val[1] = 1'b0;
    check("u1 mid accept state", 32'(state_dbg[1]), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("u1 abandoned resp_val %0d", i), 32'(resp_val[1]), 32'd0);
      check($sformatf("u1 abandoned state %0d", i), 32'(state_dbg[1]), 32'd0);
      tick();
    end
    do_read(1, 8'h07, 16'h5A5A, 0);
    do_read(0, 8'h05, 16'h1234, 1);

    // latency-1 instance
    do_load(2, 8'h10, 16'hC0DE);
    do_load(2, 8'hFF, 16'h7E57);
    do_read(2, 8'h10, 16'hC0DE, 0);
    do_read(2, 8'hFF, 16'h7E57, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
Global instruction memory endpoint that serves the memory side of the instruction fetch channel. It accepts one fetch request at a time over a val/rdy request interface and returns the addressed instruction word over a val/rdy response interface after a fixed, parameterised read latency. A separate host load port writes program words into the backing array while the block is idle. It pairs with the instruction memory controller and models global instruction memory for single-channel systems.

Parameters:
MEM_ADDR_WIDTH, 8, request/load address width
MEM_DATA_WIDTH, 16, instruction word width
MEM_DEPTH, 256, number of words in the array; legal range 1..2^MEM_ADDR_WIDTH
READ_LATENCY, 2, clock edges from request accept to first cycle of resp_val; legal range 1..15

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous reset, active-low (0 = reset)
req_rdy  output  1  responder can accept a fetch request
req_val  input  1  fetch request valid
req_addr  input  MEM_ADDR_WIDTH  fetch address (pc)
resp_rdy  input  1  requester can accept the response
resp_val  output  1  response valid
resp_inst  output  MEM_DATA_WIDTH  instruction word returned
load_val  input  1  host program-load write valid
load_addr  input  MEM_ADDR_WIDTH  load write address
load_data  input  MEM_DATA_WIDTH  load write data
load_rdy  output  1  load write accepted this cycle when load_val=1
state_dbg  output  2  current FSM state, for debugging

Behaviour:
- Reset (reset=0 at a rising edge): state=IDLE, latency counter=0, resp_val=0, resp_inst=0, captured address=0. Memory array contents are NOT cleared. Reset mid-operation abandons any in-flight request; no response is produced for it.
- FSM states: IDLE=2'd0, WAIT=2'd1, RESPOND=2'd2. state_dbg is the state register.
- req_rdy = (state==IDLE) && !load_val. load_rdy = (state==IDLE). Both are combinational from registered state and load_val.
- Load priority: in IDLE, load_val wins over req_val. A write occurs on any edge with load_val && load_rdy. Writes to load_addr >= MEM_DEPTH are silently dropped.
- IDLE: on req_val && req_rdy, capture req_addr. If READ_LATENCY==1, go directly to RESPOND with resp_inst loaded. Otherwise go to WAIT with the counter set to READ_LATENCY-1.
- WAIT: decrement the counter each edge. On the edge where the counter==1, load resp_inst from the array at the captured address, set resp_val=1, and go to RESPOND.
- resp_val first rises exactly READ_LATENCY edges after the accepting edge.
- Read of a captured address >= MEM_DEPTH returns all zeros.
- RESPOND: resp_val=1. resp_inst stays stable until the handshake completes. On resp_val && resp_rdy: resp_val<=0, resp_inst<=0, go to IDLE. req_rdy is high again the following cycle, so there are no back-to-back accepts.
- At most one request is outstanding. req_addr and req_val are ignored outside IDLE.
- The requester may hold req_val high after the response. This is re-accepted as a new request, which is harmless because reads have no side effects.
- resp_rdy is sampled only in RESPOND. Backpressure of any length is legal.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with req_val=1 -> resp_val=0, resp_inst=0, state_dbg=0, req_rdy=0 while load_val=1 else 1, load_rdy=1; no accept occurs during reset.
2. Basic read (READ_LATENCY=2): load addr 0x05 = 0xA3C1, then req_val=1 with addr 0x05 and resp_rdy=1 -> req_rdy=0 the cycle after accept; resp_val=1 with resp_inst=0xA3C1 exactly 2 edges after accept; back to IDLE after 1 response cycle.
3. Backpressure: same read with resp_rdy=0 for 4 cycles -> resp_val=1 and resp_inst=0xA3C1 held all 4 cycles; resp_rdy=1 completes the handshake, resp_inst=0 and req_rdy=1 next cycle.
4. Collision: in IDLE drive load_val=1 (addr 0x05, data 0x1234) and req_val=1 (addr 0x05) in the same cycle -> req_rdy=0, write happens; request accepted next cycle returns 0x1234.
5. Out of range (MEM_DEPTH=128): load 0xBEEF to 0xC8, then read 0xC8 -> resp_inst=0x0000; read 0x07 is unaffected.
6. Reset during WAIT (READ_LATENCY=4): drive reset=0 one edge after accept -> resp_val never rises, state_dbg=0; after release, a read of a previously loaded address returns the loaded value.
